// File: rtl/divisor_7bit_if.sv
// divisor_7bit_if: start/busy/done handshake and operand/result bus of the divider (optional div_zero under DIV_ZERO_FLAG_EN)
interface divisor_7bit_if;
  logic       start;
  logic [6:0] dividendo;
  logic [6:0] divisor;
  logic [6:0] cociente;
  logic [6:0] residuo;
  logic       done;
  logic       busy;
`ifdef DIV_ZERO_FLAG_EN
  logic       div_zero;
  modport master (output start, dividendo, divisor, input cociente, residuo, done, busy, div_zero);
  modport slave (input start, dividendo, divisor, output cociente, residuo, done, busy, div_zero);
`else
  modport master (output start, dividendo, divisor, input cociente, residuo, done, busy);
  modport slave (input start, dividendo, divisor, output cociente, residuo, done, busy);
`endif
endinterface

// File: rtl/divisor_7bit.sv
// divisor_7bit: sequential restoring 7-bit unsigned divider, one quotient bit per clock (optional div_zero output under DIV_ZERO_FLAG_EN)
module divisor_7bit (
  input logic clk,
  input logic rst,
  divisor_7bit_if.slave bus
);
  typedef enum logic {IDLE, CALC} state_t;
  state_t state, state_n;
  logic [6:0] acc, acc_n, q, q_n, d, coc, res;
  logic [7:0] acc_s;
  logic [2:0] count;
  logic done_r, fits, last, accept;
`ifdef DIV_ZERO_FLAG_EN
  logic dz;
  assign bus.div_zero = dz;
`endif
  assign bus.cociente = coc;
  assign bus.residuo = res;
  assign bus.done = done_r;
  assign bus.busy = state == CALC;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next state and one shift-subtract step; the running remainder never exceeds 7 bits after a step
  always_comb begin
    acc_s = {acc, q[6]};
    fits = acc_s >= {1'b0, d};
    acc_n = fits ? 7'(acc_s - {1'b0, d}) : acc_s[6:0];
    q_n = {q[5:0], fits};
    accept = state == IDLE && bus.start;
    last = state == CALC && count == 3'd0;
    state_n = state == IDLE ? (bus.start ? CALC : IDLE) : (last ? IDLE : CALC);
  end
  // operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      q <= '0;
      d <= '0;
      count <= '0;
      coc <= '0;
      res <= '0;
      done_r <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      dz <= 1'b0;
`endif
    end else begin
      done_r <= last;
      if (accept) begin
        acc <= '0;
        q <= bus.dividendo;
        d <= bus.divisor;
        count <= 3'd6;
      end else if (state == CALC) begin
        acc <= acc_n;
        q <= q_n;
        count <= count - 3'd1;
      end
      if (last) begin
        coc <= q_n;
        res <= acc_n;
`ifdef DIV_ZERO_FLAG_EN
        dz <= d == 7'd0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_divisor_7bit.sv
// tb_divisor_7bit: randomized and directed self-checking bench for divisor_7bit (checks div_zero when DIV_ZERO_FLAG_EN is defined)
module tb_divisor_7bit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [6:0] prev_q = 7'd0;
  logic [6:0] prev_r = 7'd0;
  logic prev_dz = 1'b0;
  divisor_7bit_if bus ();
  divisor_7bit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_held(input string tag);
    check({tag, " cociente held"}, 32'(bus.cociente), 32'(prev_q));
    check({tag, " residuo held"}, 32'(bus.residuo), 32'(prev_r));
`ifdef DIV_ZERO_FLAG_EN
    check({tag, " div_zero held"}, 32'(bus.div_zero), 32'(prev_dz));
`endif
  endtask
  // Issues one division; optionally pokes a stray start with new operands around E3.
  task automatic divide(input logic [6:0] a, input logic [6:0] b, input bit poke);
    logic [6:0] eq, er;
    int seen;
    eq = (b == 7'd0) ? 7'd127 : a / b;
    er = (b == 7'd0) ? a : a % b;
    bus.start = 1'b1;
    bus.dividendo = a;
    bus.divisor = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.dividendo = $urandom_range(0, 127);
    bus.divisor = $urandom_range(0, 127);
    check("accept busy", 32'(bus.busy), 32'd1);
    check("accept done", 32'(bus.done), 32'd0);
    check_held("accept");
    seen = 0;
    for (int i = 1; i <= 20 && seen == 0; i++) begin
      @(posedge clk);
      #1;
      if (poke && i == 2) begin
        bus.start = 1'b1;
        bus.dividendo = 7'd9;
        bus.divisor = 7'd3;
      end
      if (poke && i == 3)
        bus.start = 1'b0;
      if (bus.done) seen = i;
      else begin
        check("calc busy", 32'(bus.busy), 32'd1);
        check_held("calc");
      end
    end
    check("done edge", 32'(seen), 32'd7);
    check("done busy", 32'(bus.busy), 32'd0);
    check($sformatf("cociente %0d/%0d", a, b), 32'(bus.cociente), 32'(eq));
    check($sformatf("residuo %0d/%0d", a, b), 32'(bus.residuo), 32'(er));
`ifdef DIV_ZERO_FLAG_EN
    check("div_zero", 32'(bus.div_zero), 32'(b == 7'd0));
    prev_dz = b == 7'd0;
`endif
    prev_q = eq;
    prev_r = er;
  endtask
  task automatic idle_edge(input string tag);
    @(posedge clk);
    #1;
    check({tag, " done low"}, 32'(bus.done), 32'd0);
    check({tag, " busy low"}, 32'(bus.busy), 32'd0);
    check_held(tag);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.dividendo = 7'd0;
    bus.divisor = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset cociente", 32'(bus.cociente), 32'd0);
    check("reset residuo", 32'(bus.residuo), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
    check("reset div_zero", 32'(bus.div_zero), 32'd0);
`endif
    divide(7'd50, 7'd5, 1'b0);
    idle_edge("after 50/5");
    divide(7'd100, 7'd7, 1'b0);
    divide(7'd127, 7'd3, 1'b0);
    divide(7'd5, 7'd9, 1'b0);
    divide(7'd127, 7'd1, 1'b0);
    divide(7'd0, 7'd13, 1'b0);
    divide(7'd77, 7'd0, 1'b0);
    divide(7'd8, 7'd2, 1'b0);
    divide(7'd100, 7'd7, 1'b1);
    idle_edge("after poke");
    idle_edge("after poke 2");
    bus.start = 1'b1;
    bus.dividendo = 7'd50;
    bus.divisor = 7'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    prev_q = 7'd0;
    prev_r = 7'd0;
    prev_dz = 1'b0;
    check("abort cociente", 32'(bus.cociente), 32'd0);
    check("abort residuo", 32'(bus.residuo), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    for (int i = 0; i < 6; i++) idle_edge("post abort");
    divide(7'd20, 7'd6, 1'b0);
    for (int n = 0; n < 40; n++) begin
      logic [6:0] a, b;
      a = 7'($urandom_range(0, 127));
      b = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      divide(a, b, 1'b0);
      if ($urandom_range(0, 1) == 1) idle_edge("random gap");
    end
    idle_edge("final");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
